// File: rtl/load_align_extend.sv
// Sequential load aligner for the memory stage: issues one or two word-aligned
// reads, merges the addressed little-endian bytes and sign/zero extends them.
module load_align_extend #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_uext,
  output logic                mem_re,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [XLEN-1:0]     res_data,
  output logic                res_err,
  output logic                res_split
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RD0, CAP0, CAP1, OUT} state_t;

  state_t              state;
  logic [OFF_W-1:0]    off;
  logic [ADDR_LEN-1:0] base;
  logic [1:0]          size;
  logic                uext;
  logic                split;
  logic [XLEN-1:0]     lo_word;

  logic [OFF_W-1:0]    req_off;
  logic [ADDR_LEN-1:0] req_base;
  logic                req_split;
  logic                req_illegal;
  logic [XLEN-1:0]     lo_src;
  logic [XLEN-1:0]     hi_src;
  logic [XLEN-1:0]     sel;
  logic [XLEN-1:0]     result;

  assign req_off  = req_addr[OFF_W-1:0];
  assign req_base = {req_addr[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    req_split   = (int'(req_off) + (1 << req_size)) > NB;
    req_illegal = int'(req_size) > OFF_W;
  end

  // The merge window is {hi, lo}; hi is zero until the second word arrives.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    lo_src = (state == CAP1) ? lo_word : mem_rdata;
    hi_src = (state == CAP1) ? mem_rdata : '0;
    sel    = XLEN'({hi_src, lo_src} >> {off, 3'b000});
    result = sel;
    for (int s = 0; s < OFF_W; s++) begin
      if (size == 2'(s)) begin
        for (int b = 0; b < XLEN; b++) begin
          if (b >= (8 << s)) result[b] = uext ? 1'b0 : sel[(8 << s) - 1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      res_split <= 1'b0;
      off       <= '0;
      base      <= '0;
      size      <= '0;
      uext      <= 1'b0;
      split     <= 1'b0;
      lo_word   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off       <= req_off;
            base      <= req_base;
            size      <= req_size;
            uext      <= req_uext;
            split     <= req_split && !req_illegal;
            req_ready <= 1'b0;
            if (req_illegal) begin
              state     <= OUT;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= '0;
              res_split <= 1'b0;
            end else begin
              state    <= RD0;
              mem_re   <= 1'b1;
              mem_addr <= req_base;
            end
          end
        end
        RD0: begin
          state  <= CAP0;
          mem_re <= split;
          // Second read goes out while the first word is being captured.
          if (split) mem_addr <= base + ADDR_LEN'(NB);
        end
        CAP0: begin
          lo_word <= mem_rdata;
          mem_re  <= 1'b0;
          if (split) begin
            state <= CAP1;
          end else begin
            state     <= OUT;
            res_valid <= 1'b1;
            res_data  <= result;
            res_err   <= 1'b0;
            res_split <= 1'b0;
          end
        end
        CAP1: begin
          state     <= OUT;
          res_valid <= 1'b1;
          res_data  <= result;
          res_err   <= 1'b0;
          res_split <= 1'b1;
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_re    <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_extend.sv
// Directed bench for load_align_extend at XLEN=32 with a small synchronous
// read memory model and a log of every issued read.
module tb_load_align_extend;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uext;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_split;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] rd_addr[$];
  int          rd_cyc[$];

  load_align_extend #(.XLEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_uext(req_uext),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_split(res_split)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h8899AABB;
      32'h0000_0104: return 32'h11223344;
      32'hFFFF_FFFC: return 32'hDEADBEEF;
      32'h0000_0000: return 32'h01020304;
      default:       return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) begin
      mem_rdata <= mem_word(mem_addr);
      rd_addr.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
  end

  // Drive a request at a negedge; returns at the negedge after the accept edge.
  task automatic do_req(input logic [31:0] a, input logic [1:0] s, input logic u);
    rd_addr.delete();
    rd_cyc.delete();
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_uext  = u;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_0000;
    req_size  = 2'b00;
    req_uext  = 1'b0;
  endtask

  // Latency counted in negedges after the accept edge; 99 means timeout.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) lat = 99;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_ready, mem_re, mem_addr, res_valid, res_data, res_err, res_split} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b re=%b addr=%h v=%b d=%h e=%b s=%b expected 1 0 0 0 0 0 0",
               req_ready, mem_re, mem_addr, res_valid, res_data, res_err, res_split);
    end
  endtask

  task automatic test_byte();
    int lat;
    do_req(32'h102, 2'b00, 1'b0);
    wait_res(lat);
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL byte_latency: got %0d expected 3", lat); end
    n_cmp++;
    if (res_data !== 32'hFFFFFF99) begin n_bad++; $display("FAIL byte_sext: got %h expected ffffff99", res_data); end
    n_cmp++;
    if (res_split !== 1'b0 || res_err !== 1'b0) begin
      n_bad++; $display("FAIL byte_flags: got split=%b err=%b expected 0 0", res_split, res_err);
    end
    n_cmp++;
    if (rd_addr.size() != 1 || rd_addr[0] !== 32'h100) begin
      n_bad++; $display("FAIL byte_reads: got %0d reads expected 1 at 00000100", rd_addr.size());
    end
    consume();
    do_req(32'h102, 2'b00, 1'b1);
    wait_res(lat);
    n_cmp++;
    if (res_data !== 32'h00000099) begin n_bad++; $display("FAIL byte_zext: got %h expected 00000099", res_data); end
    consume();
  endtask

  task automatic test_split_half();
    int lat;
    do_req(32'h103, 2'b01, 1'b0);
    wait_res(lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL half_split_latency: got %0d expected 4", lat); end
    n_cmp++;
    if (res_data !== 32'h00004488) begin n_bad++; $display("FAIL half_split_data: got %h expected 00004488", res_data); end
    n_cmp++;
    if (res_split !== 1'b1) begin n_bad++; $display("FAIL half_split_flag: got %b expected 1", res_split); end
    n_cmp++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 32'h100 || rd_addr[1] !== 32'h104 || rd_cyc[1] != rd_cyc[0] + 1) begin
      n_bad++; $display("FAIL half_split_reads: got %0d reads expected 00000100 then 00000104 back to back", rd_addr.size());
    end
    consume();
  endtask

  task automatic test_word();
    int lat;
    do_req(32'h102, 2'b10, 1'b0);
    wait_res(lat);
    n_cmp++;
    if (res_data !== 32'h33448899 || res_split !== 1'b1) begin
      n_bad++; $display("FAIL word_split: got %h split=%b expected 33448899 split=1", res_data, res_split);
    end
    consume();
    do_req(32'h100, 2'b10, 1'b1);
    wait_res(lat);
    n_cmp++;
    if (res_data !== 32'h8899AABB || res_split !== 1'b0 || lat !== 3) begin
      n_bad++; $display("FAIL word_aligned: got %h split=%b lat=%0d expected 8899aabb split=0 lat=3", res_data, res_split, lat);
    end
    consume();
  endtask

  task automatic test_wrap();
    int lat;
    do_req(32'hFFFFFFFF, 2'b01, 1'b0);
    wait_res(lat);
    n_cmp++;
    if (res_data !== 32'h000004DE) begin n_bad++; $display("FAIL wrap_data: got %h expected 000004de", res_data); end
    n_cmp++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 32'hFFFFFFFC || rd_addr[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_reads: got %0d reads expected fffffffc then 00000000", rd_addr.size());
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(32'h100, 2'b00, 1'b0);
    wait_res(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({res_valid, res_data, res_split, req_ready, mem_re} !== {1'b1, 32'hFFFFFFBB, 1'b0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL hold_out_%0d: got v=%b d=%h s=%b rdy=%b re=%b expected 1 ffffffbb 0 0 0",
                 i, res_valid, res_data, res_split, req_ready, mem_re);
      end
    end
    consume();
    n_cmp++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL release_idle: got v=%b rdy=%b expected 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    res_ready = 1'b1;
    do_req(32'h104, 2'b00, 1'b1);
    wait_res(lat);
    n_cmp++;
    if (res_data !== 32'h00000044 || lat !== 3) begin
      n_bad++; $display("FAIL b2b_first: got %h lat=%0d expected 00000044 lat=3", res_data, lat);
    end
    @(posedge clk);
    @(negedge clk);
    do_req(32'h100, 2'b01, 1'b0);
    wait_res(lat);
    n_cmp++;
    if (res_data !== 32'hFFFFAABB || lat !== 3) begin
      n_bad++; $display("FAIL b2b_second: got %h lat=%0d expected ffffaabb lat=3", res_data, lat);
    end
    consume();
  endtask

  task automatic test_illegal();
    int lat;
    do_req(32'h100, 2'b11, 1'b0);
    wait_res(lat);
    n_cmp++;
    if (lat !== 1 || res_err !== 1'b1 || res_data !== 32'h0) begin
      n_bad++; $display("FAIL illegal_size: got lat=%0d err=%b d=%h expected lat=1 err=1 d=00000000", lat, res_err, res_data);
    end
    consume();
    n_cmp++;
    if (rd_addr.size() != 0) begin n_bad++; $display("FAIL illegal_no_read: got %0d reads expected 0", rd_addr.size()); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_req(32'h103, 2'b01, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, mem_re, mem_addr, res_valid, res_data, res_err, res_split} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got rdy=%b re=%b addr=%h v=%b d=%h expected 1 0 0 0 0",
               req_ready, mem_re, mem_addr, res_valid, res_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || rd_addr.size() != 1) begin
      n_bad++; $display("FAIL reset_mid_abandon: got results=%0d reads=%0d expected 0 and 1", seen, rd_addr.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_size  = 2'b00;
    req_uext  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_byte();
    test_split_half();
    test_word();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running after 200000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_align_extend.md
Name: load_align_extend

Overview:
- Sequential successor to the combinational sign/zero extender, used in the memory stage.
- Accepts a load request (byte address, access size, unsigned flag) over a valid/ready handshake and issues one or two word-aligned reads to a synchronous-read data memory.
- Selects and merges the addressed little-endian bytes, including misaligned accesses that straddle a word boundary.
- Returns the result sign- or zero-extended to XLEN through a valid/ready result port.

Parameters:
- XLEN, 32, data word width in bits; legal values 32 or 64. NB = XLEN/8 bytes per word.
- ADDR_LEN, 32, byte address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_addr  input  ADDR_LEN  byte address of the load.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 doubleword. 11 is legal only when XLEN=64.
- req_uext  input  1  1 selects zero extension, 0 selects sign extension.
- mem_re  output  1  memory read strobe.
- mem_addr  output  ADDR_LEN  word-aligned read address; low log2(NB) bits are always 0.
- mem_rdata  input  XLEN  read data, valid the cycle after mem_re.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  XLEN  aligned and extended load result.
- res_err  output  1  illegal size; qualified by res_valid.
- res_split  output  1  the access needed two reads; qualified by res_valid.

Behaviour:
- Reset (asynchronous, reset=0):
  - state goes to IDLE.
  - req_ready=1; mem_re=0; mem_addr=0; res_valid=0; res_data=0; res_err=0; res_split=0.
  - Reset asserted mid-operation abandons the request; no result is produced.
- Latched fields:
  - Request is accepted when req_valid && req_ready.
  - Latch off = addr[log2(NB)-1:0], base = addr with the low bits cleared, size, uext.
  - nbytes = 2^size.
  - split = (off + nbytes > NB).
  - illegal = (size > log2(NB)).
- State machine:
  - IDLE: req_ready=1. On accept: if illegal go to OUT with res_err=1, res_data=0 and no memory access; else go to RD0.
  - RD0: mem_re=1, mem_addr=base. Next state CAP0.
  - CAP0: capture mem_rdata into lo_word.
    - If split: mem_re=1, mem_addr=base+NB in the same cycle, then go to CAP1. The addition wraps modulo 2^ADDR_LEN.
    - Else: form the result and go to OUT.
  - CAP1: capture mem_rdata into hi_word, form the result and go to OUT.
  - OUT: res_valid=1, and res_data/res_err/res_split are held stable. On res_ready go to IDLE. No request is accepted in the same cycle.
- Latency:
  - Accept at edge T gives res_valid at T+3 (aligned) or T+4 (split). The same applies with res_ready tied high.
  - Illegal size gives res_valid at T+1.
  - Throughput is one request per result handshake plus one IDLE cycle.
- Byte selection:
  - Form the 2*NB-byte concatenation {hi_word, lo_word}; hi_word is 0 when not split.
  - Take nbytes bytes starting at byte lane off, little-endian.
- Extension:
  - For nbytes < NB: if uext, upper bits = 0; else upper bits replicate bit (8*nbytes-1) of the selected data.
  - For nbytes == NB: req_uext is ignored and the result is the raw selected bytes.
- mem_re is never asserted outside RD0 and CAP0. mem_addr holds its last value when mem_re=0.
- Input ports other than the handshake signals are ignored outside IDLE.

Test Plan:
XLEN=32. Memory: 0x100=0x8899AABB, 0x104=0x11223344, 0xFFFFFFFC=0xDEADBEEF, 0x0=0x01020304.
1. Byte at 0x102, uext=0 → one read at 0x100; res_data=0xFFFFFF99, res_split=0, res_valid at T+3. With uext=1 → 0x00000099.
2. Half at 0x103, uext=0 → reads at 0x100 then 0x104 on consecutive cycles; res_data=0x00004488, res_split=1, res_valid at T+4.
3. Word at 0x102 → res_data=0x33448899, split=1. Word at 0x100 with uext=1 → 0x8899AABB, no extension applied.
4. Half at 0xFFFFFFFF, uext=0 → second mem_addr=0x00000000 (wrap); res_data=0x000004DE.
5. res_ready held low 3 cycles in OUT → res_valid, res_data and res_split remain stable, req_ready=0 and mem_re=0 throughout. Release → IDLE next cycle.
6. req_size=11 → res_err=1 and res_data=0 at T+1, with no mem_re. Separately: assert reset during CAP0 of a split load → outputs at reset values immediately, no second read, no result.
